// File: rtl/sensor_pkg.sv
// Sensor input conditioning: shared defaults and types.
// Debounce lengths, ADC timeout and tracker state encoding.
package sensor_pkg;

  localparam int DEB_N_DEF   = 4;
  localparam int ADC_N_DEF   = 3;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_STABLE = 2'd0,
    ST_CAND   = 2'd1,
    ST_FAULT  = 2'd2
  } trk_state_t;

  typedef struct packed {
    logic [3:0] adc;
    logic       humo;
    logic       el;
  } raw_t;

endpackage

// File: rtl/sensor_debounce_if.sv
// Sensor bundle: raw contacts and ADC bits in,
// conditioned levels, ADC code and status out.
interface sensor_debounce_if;

  logic       sample_tick;
  logic [3:0] adc_raw;
  logic       humo_raw;
  logic       el_raw;
  logic [3:0] adc_q;
  logic       humo_q;
  logic       el_q;
  logic       adc_upd;
  logic       adc_fault;

  modport master (
    output sample_tick,
    output adc_raw,
    output humo_raw,
    output el_raw,
    input  adc_q,
    input  humo_q,
    input  el_q,
    input  adc_upd,
    input  adc_fault
  );

  modport slave (
    input  sample_tick,
    input  adc_raw,
    input  humo_raw,
    input  el_raw,
    output adc_q,
    output humo_q,
    output el_q,
    output adc_upd,
    output adc_fault
  );

endinterface

// File: rtl/debounce_bit.sv
// Counter debounce of one synchronized bit.
// Output flips after DEB_N consecutive differing ticks.
module debounce_bit
  import sensor_pkg::*;
#(
  parameter int DEB_N = DEB_N_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic din,
  output logic q
);

  localparam logic [3:0] CNT_MAX = 4'(DEB_N - 1);

  logic [3:0] cnt;

  // count differing ticks; any agreeing tick restarts
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (tick) begin
      if (din == q) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        q   <= din;
        cnt <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/sensor_debounce.sv
// Sensor conditioning top: sync, humo/el debounce,
// ADC code acceptance tracker with settle timeout.
module sensor_debounce
  import sensor_pkg::*;
#(
  parameter int DEB_N   = DEB_N_DEF,
  parameter int ADC_N   = ADC_N_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic               clk,
  input logic               reset,
  sensor_debounce_if.slave  bus
);

  localparam logic [2:0] MATCH_MAX = 3'(ADC_N - 1);
  localparam logic [7:0] STALE_MAX = 8'(TIMEOUT);

  raw_t       s1;
  raw_t       s2;
  logic       tick;
  logic       humo_q;
  logic       el_q;
  logic [3:0] prev;
  logic [2:0] match;
  logic [2:0] match_nxt;
  logic [7:0] stale;
  logic [7:0] stale_inc;
  logic [3:0] adc_q;
  logic       upd;
  logic       fault;
  logic       conf;
  logic       diff;
  trk_state_t st;

  assign tick = bus.sample_tick;

  // two-flop synchronizer on every raw input
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= '{adc: bus.adc_raw,
              humo: bus.humo_raw,
              el: bus.el_raw};
      s2 <= s1;
    end
  end

  debounce_bit #(.DEB_N(DEB_N)) u_humo (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .din   (s2.humo),
    .q     (humo_q)
  );

  debounce_bit #(.DEB_N(DEB_N)) u_el (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .din   (s2.el),
    .q     (el_q)
  );

  // match run length, confirm and timeout helpers
  always_comb begin
    match_nxt = '0;
    if (s2.adc == prev) begin
      match_nxt = (match == MATCH_MAX) ?
                  match : match + 3'd1;
    end
    conf      = (match_nxt == MATCH_MAX);
    diff      = (s2.adc != adc_q);
    stale_inc = (stale >= STALE_MAX) ?
                STALE_MAX : stale + 8'd1;
  end

  // ADC acceptance tracker FSM, registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= ST_STABLE;
      prev  <= '0;
      match <= '0;
      stale <= '0;
      adc_q <= '0;
      upd   <= 1'b0;
      fault <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (tick) begin
        prev  <= s2.adc;
        match <= match_nxt;
        unique case (st)
          ST_STABLE: begin
            if (diff) begin
              stale <= 8'd1;
              if (STALE_MAX <= 8'd1) begin
                st    <= ST_FAULT;
                fault <= 1'b1;
              end else begin
                st <= ST_CAND;
              end
            end else begin
              stale <= '0;
            end
          end
          ST_CAND: begin
            if (conf) begin
              if (diff) begin
                adc_q <= s2.adc;
                upd   <= 1'b1;
              end
              stale <= '0;
              st    <= ST_STABLE;
            end else begin
              stale <= stale_inc;
              if (stale_inc >= STALE_MAX) begin
                st    <= ST_FAULT;
                fault <= 1'b1;
              end
            end
          end
          ST_FAULT: begin
            if (conf) begin
              if (diff) begin
                adc_q <= s2.adc;
                upd   <= 1'b1;
              end
              fault <= 1'b0;
              stale <= '0;
              st    <= ST_STABLE;
            end else begin
              stale <= stale_inc;
            end
          end
          default: begin
            st <= ST_STABLE;
          end
        endcase
      end
    end
  end

  assign bus.adc_q     = adc_q;
  assign bus.humo_q    = humo_q;
  assign bus.el_q      = el_q;
  assign bus.adc_upd   = upd;
  assign bus.adc_fault = fault;

endmodule

// File: tb/tb_sensor_debounce.sv
// Directed bench for sensor_debounce:
// debounce, ADC accept, timeout fault, reset, idle.
module tb_sensor_debounce;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  sensor_debounce_if bus ();

  sensor_debounce #(
    .DEB_N   (4),
    .ADC_N   (3),
    .TIMEOUT (8)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // one sample tick, 10 clk period; returns at the
  // negedge right after the tick was sampled
  task automatic do_tick();
    repeat (9) @(negedge clk);
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
  endtask

  task automatic check_all(input string tag,
                           input logic [7:0] exp);
    check(tag, {bus.adc_q, bus.humo_q, bus.el_q,
                bus.adc_upd, bus.adc_fault}, exp);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    bus.sample_tick = 1'b1;
    bus.adc_raw  = 4'h0;
    bus.humo_raw = 1'b0;
    bus.el_raw   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus.sample_tick = 1'b0;
    check_all("reset_state", 8'h00);

    // humo 0->1: flips on the 4th tick only
    bus.humo_raw = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      do_tick();
      check("humo_early", bus.humo_q, 1'b0);
    end
    do_tick();
    check("humo_set", bus.humo_q, 1'b1);

    // el glitch of 3 ticks never reaches el_q
    bus.el_raw = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      do_tick();
      check("el_pulse", bus.el_q, 1'b0);
    end
    bus.el_raw = 1'b0;
    repeat (2) do_tick();
    check("el_after", bus.el_q, 1'b0);
    check("humo_hold", bus.humo_q, 1'b1);

    // ADC 0000->1010 accepted on 3rd tick
    bus.adc_raw = 4'b1010;
    do_tick();
    check("adc_t1", {bus.adc_q, bus.adc_upd}, 5'h00);
    do_tick();
    check("adc_t2", {bus.adc_q, bus.adc_upd}, 5'h00);
    do_tick();
    check("adc_t3_q", bus.adc_q, 4'b1010);
    check("adc_t3_upd", bus.adc_upd, 1'b1);
    @(negedge clk);
    check("adc_upd_1clk", bus.adc_upd, 1'b0);

    // toggling ADC: fault after 8 ticks, code held
    for (int i = 1; i <= 9; i++) begin
      bus.adc_raw = (i % 2 == 1) ? 4'b0101 : 4'b0110;
      do_tick();
      if (i == 7)
        check("fault_t7", bus.adc_fault, 1'b0);
      if (i >= 8) begin
        check("fault_set", bus.adc_fault, 1'b1);
        check("fault_q", bus.adc_q, 4'b1010);
      end
      check("toggle_upd", bus.adc_upd, 1'b0);
    end
    bus.adc_raw = 4'b0110;
    repeat (2) do_tick();
    check("rec_t2", {bus.adc_q, bus.adc_upd,
                     bus.adc_fault}, 6'b1010_0_1);
    do_tick();
    check("rec_t3", {bus.adc_q, bus.adc_upd,
                     bus.adc_fault}, 6'b0110_1_0);

    // humo 1->0 also takes 4 ticks
    bus.humo_raw = 1'b0;
    repeat (3) do_tick();
    check("humo_fall_early", bus.humo_q, 1'b1);
    do_tick();
    check("humo_fall", bus.humo_q, 1'b0);

    // reset on a tick two ticks into a humo change
    bus.humo_raw = 1'b1;
    bus.adc_raw  = 4'h0;
    repeat (2) do_tick();
    check("pre_rst_humo", bus.humo_q, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    bus.sample_tick = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.sample_tick = 1'b0;
    check_all("rst_mid", 8'h00);
    for (int i = 1; i <= 3; i++) begin
      do_tick();
      check("rst_restart", bus.humo_q, 1'b0);
    end
    do_tick();
    check("rst_humo_set", bus.humo_q, 1'b1);
    check_all("rst_final", 8'h08);

    // no ticks: outputs frozen while inputs churn
    for (int i = 0; i < 1000; i++) begin
      bus.adc_raw  = 4'($urandom);
      bus.humo_raw = 1'($urandom);
      bus.el_raw   = 1'($urandom);
      @(negedge clk);
      check_all("idle_hold", 8'h08);
    end

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
